// File: rtl/tmr_fault_manager.sv
// Persistent-fault supervisor for three NAND flash controller replicas: votes their
// outputs, masks a persistently dissenting replica, and resynchronises all three at idle.
module tmr_fault_manager #(
  parameter int W              = 32,
  parameter int MISMATCH_LIMIT = 4,
  parameter int RST_CYCLES     = 8,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       rep_a,
  input  logic [W-1:0]       rep_b,
  input  logic [W-1:0]       rep_c,
  input  logic               sync_ok,
  output logic [W-1:0]       data_out,
  output logic [2:0]         rep_mask,
  output logic [2:0]         rep_rst,
  output logic               tmr_error,
  output logic [3*CNT_W-1:0] fault_cnt,
  output logic [1:0]         state
);

  localparam logic [1:0] ST_NORMAL  = 2'b00;
  localparam logic [1:0] ST_FAULTED = 2'b01;
  localparam logic [1:0] ST_RESYNC  = 2'b10;

  localparam int SW = $clog2(MISMATCH_LIMIT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [SW-1:0]    STREAK_LAST = SW'(MISMATCH_LIMIT - 1);
  localparam logic [RW-1:0]    RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]             state_q, state_d;
  logic [2:0]             mask_q, mask_d;
  logic [2:0]             rrst_q, rrst_d;
  logic                   err_q, err_d;
  logic [2:0][CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [2:0][SW-1:0]     streak_q, streak_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;

  logic [2:0] dissent;
  logic [2:0] single;
  logic       all_diff;
  logic       pair_diff;
  logic       fault_hit;

  assign dissent[0] = (rep_a != rep_b) && (rep_a != rep_c);
  assign dissent[1] = (rep_b != rep_a) && (rep_b != rep_c);
  assign dissent[2] = (rep_c != rep_a) && (rep_c != rep_b);
  assign all_diff   = &dissent;
  assign single     = dissent & {3{~all_diff}};

  always_comb begin
    case (mask_q)
      3'b001:  pair_diff = (rep_b != rep_c);
      3'b010:  pair_diff = (rep_a != rep_c);
      3'b100:  pair_diff = (rep_a != rep_b);
      default: pair_diff = 1'b0;
    endcase
  end

  // With a replica masked the surviving pair is trusted as-is: lowest healthy index wins.
  always_comb begin
    if (mask_q == 3'b000)
      data_out = (rep_a & rep_b) | (rep_b & rep_c) | (rep_a & rep_c);
    else if (mask_q[0])
      data_out = rep_b;
    else
      data_out = rep_a;
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    rrst_d    = rrst_q;
    err_d     = 1'b0;
    fcnt_d    = fcnt_q;
    streak_d  = '0;
    rcnt_d    = rcnt_q;
    fault_hit = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        err_d = all_diff;
        for (int unsigned i = 0; i < 3; i++) begin
          if (single[i]) begin
            streak_d[i] = streak_q[i] + SW'(1);
            if (streak_q[i] == STREAK_LAST) begin
              fault_hit = 1'b1;
              mask_d[i] = 1'b1;
              if (fcnt_q[i] != CNT_MAX)
                fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
            end
          end
        end
        if (fault_hit) begin
          streak_d = '0;
          state_d  = ST_FAULTED;
        end
      end
      ST_FAULTED: begin
        err_d = pair_diff;
        if (sync_ok) begin
          state_d = ST_RESYNC;
          rrst_d  = '1;
          rcnt_d  = '0;
        end
      end
      ST_RESYNC: begin
        if (rcnt_q == RST_LAST) begin
          rrst_d  = '0;
          mask_d  = '0;
          state_d = ST_NORMAL;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = ST_NORMAL;
        mask_d  = '0;
        rrst_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      mask_q   <= '0;
      rrst_q   <= '0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
      streak_q <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      rrst_q   <= rrst_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
      streak_q <= streak_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign rep_mask  = mask_q;
  assign rep_rst   = rrst_q;
  assign tmr_error = err_q;
  assign fault_cnt = fcnt_q;
  assign state     = state_q;

endmodule
